// File: rtl/dx_pkg.sv
// Shared opcode/ALU constants, FSM state and decoded control payload for the D/X stage.
package dx_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dx_state_e;

    typedef struct packed {
        logic       is_itype;
        logic       is_jump;
        logic       is_mult;
        logic       is_div;
        logic [4:0] alu_op;
        logic [4:0] shamt;
    } dx_ctrl_t;

endpackage

// File: rtl/dx_decode_comb.sv
// Purely combinational instruction decode: class flags, ALU op, shift amount,
// sign-extended I-type immediate and zero-extended jump target.
module dx_decode_comb
    import dx_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [31:0]       instr_i,
    output dx_ctrl_t          ctrl_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] jump_tgt_o
);

    logic [4:0] op;

    assign op = instr_i[31:27];

    always_comb begin
        ctrl_o       = '0;
        ctrl_o.shamt = instr_i[11:7];
        case (op)
            OP_ADDI, OP_SW, OP_LW: ctrl_o.is_itype = 1'b1;
            OP_J:                  ctrl_o.is_jump  = 1'b1;
            OP_RTYPE: begin
                ctrl_o.alu_op  = instr_i[6:2];
                ctrl_o.is_mult = (instr_i[6:2] == ALU_MULT);
                ctrl_o.is_div  = (instr_i[6:2] == ALU_DIV);
            end
            default: ;
        endcase
    end

    assign imm_o      = {{(DATA_W - 17){instr_i[16]}}, instr_i[16:0]};
    assign jump_tgt_o = {{(DATA_W - 27){1'b0}}, instr_i[26:0]};

endmodule

// File: rtl/dx_pipe_stage.sv
// Decode/execute pipeline stage: operand forwarding muxes, registered D/X slot with
// valid/ready handshake, and the issue interlock for the multicycle mult/div unit.
module dx_pipe_stage
    import dx_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned N_FWD      = 3,
    parameter int unsigned MD_TIMEOUT = 40
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [DATA_W-1:0]            reg_a,
    input  logic [DATA_W-1:0]            reg_b,
    input  logic [$clog2(N_FWD+1)-1:0]   fwd_sel_a,
    input  logic [$clog2(N_FWD+1)-1:0]   fwd_sel_b,
    input  logic [N_FWD*DATA_W-1:0]      fwd_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_a,
    output logic [DATA_W-1:0]            out_b,
    output logic [4:0]                   out_alu_op,
    output logic [4:0]                   out_shamt,
    output logic                         out_is_jump,
    output logic                         out_is_mult,
    output logic                         out_is_div,
    output logic [DATA_W-1:0]            out_jump_tgt,
    output logic                         md_start,
    input  logic                         md_done,
    output logic                         md_abort,
    output logic                         md_timeout
);

    localparam int unsigned SEL_W = $clog2(N_FWD + 1);
    localparam int unsigned CNT_W = $clog2(MD_TIMEOUT);

    dx_ctrl_t          dec_ctrl;
    logic [DATA_W-1:0] dec_imm;
    logic [DATA_W-1:0] dec_tgt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              capture;
    logic              transfer;

    dx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_a_q, out_b_q, out_tgt_q;
    logic [4:0]        out_alu_q, out_shamt_q;
    logic              out_jump_q, out_mult_q, out_div_q;

    dx_decode_comb #(
        .DATA_W(DATA_W)
    ) u_decode (
        .instr_i    (in_instr),
        .ctrl_o     (dec_ctrl),
        .imm_o      (dec_imm),
        .jump_tgt_o (dec_tgt)
    );

    // Select values above N_FWD fall through to the register file.
    always_comb begin
        op_a = reg_a;
        op_b = reg_b;
        for (int unsigned k = 1; k <= N_FWD; k++) begin
            if (fwd_sel_a == SEL_W'(k)) op_a = fwd_data[(k-1)*DATA_W +: DATA_W];
            if (fwd_sel_b == SEL_W'(k)) op_b = fwd_data[(k-1)*DATA_W +: DATA_W];
        end
    end

    assign in_ready = reset_n && !flush && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign capture  = in_valid && in_ready;
    assign transfer = out_valid_q && out_ready;

    // Interlock FSM; a flushed mult/div slot never issues.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_start   = 1'b0;
        md_abort   = 1'b0;
        md_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer && !flush && (out_mult_q || out_div_q)) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    md_start = 1'b1;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d  = IDLE;
                    md_abort = 1'b1;
                end else if (md_done) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
                    state_d    = IDLE;
                    md_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_tgt_q   <= '0;
            out_alu_q   <= '0;
            out_shamt_q <= '0;
            out_jump_q  <= 1'b0;
            out_mult_q  <= 1'b0;
            out_div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush)         out_valid_q <= 1'b0;
            else if (capture)  out_valid_q <= 1'b1;
            else if (transfer) out_valid_q <= 1'b0;
            if (capture) begin
                out_a_q     <= op_a;
                out_b_q     <= dec_ctrl.is_itype ? dec_imm : op_b;
                out_tgt_q   <= dec_tgt;
                out_alu_q   <= dec_ctrl.alu_op;
                out_shamt_q <= dec_ctrl.shamt;
                out_jump_q  <= dec_ctrl.is_jump;
                out_mult_q  <= dec_ctrl.is_mult;
                out_div_q   <= dec_ctrl.is_div;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_a        = out_a_q;
    assign out_b        = out_b_q;
    assign out_jump_tgt = out_tgt_q;
    assign out_alu_op   = out_alu_q;
    assign out_shamt    = out_shamt_q;
    assign out_is_jump  = out_jump_q;
    assign out_is_mult  = out_mult_q;
    assign out_is_div   = out_div_q;

endmodule

// File: tb/tb_dx_pipe_stage.sv
// Self-checking bench for dx_pipe_stage: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the stage.
module tb_dx_pipe_stage;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned N_FWD      = 5;
    localparam int unsigned MD_TIMEOUT = 8;
    localparam int unsigned SEL_W      = $clog2(N_FWD + 1);

    logic                    clock     = 1'b0;
    logic                    reset_n   = 1'b0;
    logic                    in_valid  = 1'b0;
    logic                    in_ready;
    logic [31:0]             in_instr  = '0;
    logic [DATA_W-1:0]       reg_a     = '0;
    logic [DATA_W-1:0]       reg_b     = '0;
    logic [SEL_W-1:0]        fwd_sel_a = '0;
    logic [SEL_W-1:0]        fwd_sel_b = '0;
    logic [N_FWD*DATA_W-1:0] fwd_data;
    logic                    flush     = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [DATA_W-1:0]       out_a, out_b, out_jump_tgt;
    logic [4:0]              out_alu_op, out_shamt;
    logic                    out_is_jump, out_is_mult, out_is_div;
    logic                    md_start, md_abort, md_timeout;
    logic                    md_done   = 1'b0;

    logic [DATA_W-1:0]       fwd_arr [N_FWD];
    int                      checks = 0;
    int                      errors = 0;

    always #5 clock = ~clock;

    always_comb begin
        for (int k = 0; k < int'(N_FWD); k++) fwd_data[k*DATA_W +: DATA_W] = fwd_arr[k];
    end

    dx_pipe_stage #(
        .DATA_W(DATA_W), .N_FWD(N_FWD), .MD_TIMEOUT(MD_TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .reg_a(reg_a), .reg_b(reg_b),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op), .out_shamt(out_shamt),
        .out_is_jump(out_is_jump), .out_is_mult(out_is_mult), .out_is_div(out_is_div),
        .out_jump_tgt(out_jump_tgt), .md_start(md_start), .md_done(md_done),
        .md_abort(md_abort), .md_timeout(md_timeout)
    );

    // Reference decode rules, written directly from the instruction format.
    function automatic bit ref_itype(input logic [31:0] w);
        int op;
        op = int'(w[31:27]);
        return (op == 5) || (op == 7) || (op == 8);
    endfunction

    function automatic logic [DATA_W-1:0] ref_sext(input logic [31:0] w);
        return w[16] ? ({15'h7FFF, w[16:0]}) : ({15'h0000, w[16:0]});
    endfunction

    function automatic logic [DATA_W-1:0] ref_sel(input int sel, input logic [DATA_W-1:0] rf);
        if (sel >= 1 && sel <= int'(N_FWD)) return fwd_arr[sel-1];
        return rf;
    endfunction

    function automatic logic [31:0] mk_op(input logic [4:0] op);
        logic [31:0] w;
        w = $urandom;
        w[31:27] = op;
        return w;
    endfunction

    function automatic logic [31:0] mk_rtype(input logic [4:0] alu);
        logic [31:0] w;
        w = mk_op(5'd0);
        w[6:2] = alu;
        return w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_instr = mk_op(5'd5);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if ({md_start, md_abort, md_timeout} !== 3'b000) begin errors++; $display("FAIL reset_md got %b want 000", {md_start, md_abort, md_timeout}); end
        checks++; if ({out_a, out_b, out_jump_tgt} !== '0) begin errors++; $display("FAIL reset_data got %h %h %h want 0", out_a, out_b, out_jump_tgt); end
        checks++; if ({out_alu_op, out_shamt, out_is_jump, out_is_mult, out_is_div} !== 13'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", {out_alu_op, out_shamt, out_is_jump, out_is_mult, out_is_div}); end
        in_valid = 1'b0; reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_decode_addi();
        in_instr = {5'b00101, 10'h155, 17'h1FFFF}; fwd_sel_a = '0; fwd_sel_b = '0;
        reg_a = 32'd5; reg_b = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
        checks++; if (out_a !== 32'd5) begin errors++; $display("FAIL addi_a got %h want 5", out_a); end
        checks++; if (out_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", out_b); end
        checks++; if ({out_alu_op, out_shamt} !== {5'd0, 5'h1F}) begin errors++; $display("FAIL addi_alu_shamt got %h %h want 0 1f", out_alu_op, out_shamt); end
        checks++; if (out_jump_tgt !== 32'h02ABFFFF) begin errors++; $display("FAIL addi_tgt got %h want 02abffff", out_jump_tgt); end
        checks++; if ({out_is_jump, out_is_mult, out_is_div} !== 3'b000) begin errors++; $display("FAIL addi_flags got %b want 000", {out_is_jump, out_is_mult, out_is_div}); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %b want 0", out_valid); end
    endtask

    task automatic test_forwarding();
        int sels [5] = '{2, 6, 7, 5, 0};
        int sb;
        logic [DATA_W-1:0] exp_a, exp_b;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < int'(N_FWD); k++) fwd_arr[k] = $urandom;
            fwd_arr[1] = 32'h0000CAFE;
            reg_a = $urandom; reg_b = $urandom;
            sb = int'($urandom_range(0, 7));
            fwd_sel_a = SEL_W'(sels[i]); fwd_sel_b = SEL_W'(sb);
            in_instr = mk_rtype(5'd1); in_valid = 1'b1;
            exp_a = ref_sel(sels[i], reg_a);
            exp_b = ref_sel(sb, reg_b);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid[%0d] got %b want 1", i, out_valid); end
            checks++; if (out_a !== exp_a) begin errors++; $display("FAIL fwd_a[sel %0d] got %h want %h", sels[i], out_a, exp_a); end
            checks++; if (out_b !== exp_b) begin errors++; $display("FAIL fwd_b[sel %0d] got %h want %h", sb, out_b, exp_b); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] va, vb;
        fwd_sel_a = '0; fwd_sel_b = '0;
        va = $urandom; vb = va ^ 32'h5A5A0001;
        reg_a = va; in_instr = mk_rtype(5'd2); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        reg_a = vb; in_instr = mk_rtype(5'd3); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
            tick();
            checks++; if ({out_valid, out_a, out_alu_op} !== {1'b1, va, 5'd2}) begin errors++; $display("FAIL bp_hold[%0d] got %b %h %h want 1 %h 02", i, out_valid, out_a, out_alu_op, va); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, out_a, out_alu_op} !== {1'b1, vb, 5'd3}) begin errors++; $display("FAIL bp_next got %b %h %h want 1 %h 03", out_valid, out_a, out_alu_op, vb); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0 (duplicate)", out_valid); end
    endtask

    task automatic test_mult_interlock();
        logic [DATA_W-1:0] vn;
        fwd_sel_a = '0;
        reg_a = $urandom; in_instr = mk_rtype(5'b00110); in_valid = 1'b1; out_ready = 1'b0;
        tick();
        checks++; if (out_is_mult !== 1'b1) begin errors++; $display("FAIL mult_flag got %b want 1", out_is_mult); end
        in_valid = 1'b0; out_ready = 1'b1; md_done = 1'b1;
        #1;
        checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL mult_start got %b want 1", md_start); end
        tick();
        md_done = 1'b0;
        vn = $urandom; reg_a = vn; in_instr = mk_op(5'd5); in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            md_done = (i == 5);
            #1;
            checks++; if ({in_ready, md_start, md_timeout, out_valid} !== 4'b0000) begin errors++; $display("FAIL mult_busy[%0d] ready/start/timeout/valid got %b want 0000", i, {in_ready, md_start, md_timeout, out_valid}); end
            tick();
        end
        md_done = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mult_release got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, out_a} !== {1'b1, vn}) begin errors++; $display("FAIL mult_next got %b %h want 1 %h", out_valid, out_a, vn); end
        tick();
    endtask

    task automatic test_watchdog();
        reg_a = $urandom; in_instr = mk_rtype(5'b00111); in_valid = 1'b1; out_ready = 1'b0;
        tick();
        checks++; if (out_is_div !== 1'b1) begin errors++; $display("FAIL div_flag got %b want 1", out_is_div); end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL div_start got %b want 1", md_start); end
        tick();
        for (int i = 1; i <= 8; i++) begin
            #1;
            checks++; if ({md_timeout, in_ready} !== {(i == 8), 1'b0}) begin errors++; $display("FAIL wd_cycle[%0d] timeout/ready got %b want %b0", i, {md_timeout, in_ready}, (i == 8)); end
            tick();
        end
        #1;
        checks++; if ({md_timeout, in_ready} !== 2'b01) begin errors++; $display("FAIL wd_idle timeout/ready got %b want 01", {md_timeout, in_ready}); end
    endtask

    task automatic test_flush();
        in_instr = mk_rtype(5'b00110); in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        #1;
        checks++; if ({md_start, in_ready} !== 2'b00) begin errors++; $display("FAIL flush_xfer start/ready got %b want 00", {md_start, in_ready}); end
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_no_busy got %b want 1", in_ready); end
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL flush_b_start got %b want 1", md_start); end
        tick();
        #1;
        checks++; if (md_abort !== 1'b0) begin errors++; $display("FAIL abort_early got %b want 0", md_abort); end
        tick();
        flush = 1'b1;
        #1;
        checks++; if (md_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse got %b want 1", md_abort); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if ({md_abort, in_ready} !== 2'b01) begin errors++; $display("FAIL abort_idle abort/ready got %b want 01", {md_abort, in_ready}); end
    endtask

    task automatic test_reset_busy();
        in_instr = mk_rtype(5'b00110); in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checks++; if ({md_abort, in_ready, out_valid} !== 3'b000) begin errors++; $display("FAIL rstbusy abort/ready/valid got %b want 000", {md_abort, in_ready, out_valid}); end
        tick();
        reset_n = 1'b1;
        #1;
        checks++; if ({in_ready, md_timeout} !== 2'b10) begin errors++; $display("FAIL rstbusy_idle ready/timeout got %b want 10", {in_ready, md_timeout}); end
    endtask

    task automatic test_random();
        logic [4:0]        ops [5] = '{5'd0, 5'd1, 5'd5, 5'd7, 5'd8};
        logic              m_ov, m_busy, m_j, m_m, m_d;
        int                m_cnt, sa, sb;
        logic [DATA_W-1:0] m_a, m_b, m_tgt;
        logic [4:0]        m_alu, m_sh, op;
        logic              e_rdy, e_start, e_abort, e_to;
        logic [31:0]       w;
        m_ov = 1'b0; m_busy = 1'b0; m_cnt = 0;
        m_a = '0; m_b = '0; m_tgt = '0; m_alu = '0; m_sh = '0; m_j = 1'b0; m_m = 1'b0; m_d = 1'b0;
        for (int c = 0; c < 400; c++) begin
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", c, out_valid, m_ov); end
            if (m_ov) begin
                checks++; if ({out_a, out_b, out_jump_tgt} !== {m_a, m_b, m_tgt}) begin errors++; $display("FAIL rnd_data[%0d] got %h %h %h want %h %h %h", c, out_a, out_b, out_jump_tgt, m_a, m_b, m_tgt); end
                checks++; if ({out_alu_op, out_shamt, out_is_jump, out_is_mult, out_is_div} !== {m_alu, m_sh, m_j, m_m, m_d}) begin errors++; $display("FAIL rnd_ctrl[%0d] got %h want %h", c, {out_alu_op, out_shamt, out_is_jump, out_is_mult, out_is_div}, {m_alu, m_sh, m_j, m_m, m_d}); end
            end
            for (int k = 0; k < int'(N_FWD); k++) fwd_arr[k] = $urandom;
            reg_a = $urandom; reg_b = $urandom;
            sa = int'($urandom_range(0, 7)); sb = int'($urandom_range(0, 7));
            fwd_sel_a = SEL_W'(sa); fwd_sel_b = SEL_W'(sb);
            op = ops[$urandom_range(0, 4)];
            w = mk_op(op);
            if (op == 5'd0) begin
                case ($urandom_range(0, 2))
                    0: w[6:2] = 5'b00110;
                    1: w[6:2] = 5'b00111;
                    default: ;
                endcase
            end
            in_instr  = w;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            md_done   = ($urandom_range(0, 9) == 0);
            #1;
            e_rdy   = !flush && !m_busy && (!m_ov || out_ready);
            e_start = !m_busy && m_ov && out_ready && !flush && (m_m || m_d);
            e_abort = m_busy && flush;
            e_to    = m_busy && !flush && !md_done && (m_cnt == int'(MD_TIMEOUT) - 1);
            checks++; if ({in_ready, md_start, md_abort, md_timeout} !== {e_rdy, e_start, e_abort, e_to}) begin errors++; $display("FAIL rnd_comb[%0d] ready/start/abort/timeout got %b want %b", c, {in_ready, md_start, md_abort, md_timeout}, {e_rdy, e_start, e_abort, e_to}); end
            if (e_start) begin
                m_busy = 1'b1; m_cnt = 0;
            end else if (m_busy) begin
                if (flush || md_done || m_cnt == int'(MD_TIMEOUT) - 1) m_busy = 1'b0;
                else m_cnt++;
            end
            if (flush) begin
                m_ov = 1'b0;
            end else if (in_valid && e_rdy) begin
                m_ov  = 1'b1;
                m_a   = ref_sel(sa, reg_a);
                m_b   = ref_itype(w) ? ref_sext(w) : ref_sel(sb, reg_b);
                m_tgt = {5'd0, w[26:0]};
                m_alu = (w[31:27] == 5'd0) ? w[6:2] : 5'd0;
                m_sh  = w[11:7];
                m_j   = (w[31:27] == 5'd1);
                m_m   = (w[31:27] == 5'd0) && (w[6:2] == 5'd6);
                m_d   = (w[31:27] == 5'd0) && (w[6:2] == 5'd7);
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; md_done = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < int'(N_FWD); k++) fwd_arr[k] = '0;
        test_reset();
        test_decode_addi();
        test_forwarding();
        test_backpressure();
        test_mult_interlock();
        test_watchdog();
        test_flush();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
